pipe_mem: RTL and testbench

Memory stage of the five-stage pipeline, directly downstream of the execute stage. Registers the execute-stage results into the EX/MEM pipeline register, then performs word loads and stores against a local data memory. Presents write-back controls, the ALU result and the load data to the MEM/WB register. Also exposes the MEM-stage destination for the forwarding unit.

---
 rtl/pipe_mem.sv | 68 ++++++
 tb/tb_pipe_mem.sv | 110 +++++++++++
 2 files changed

// File: rtl/pipe_mem.sv
// pipe_mem: EX/MEM pipeline register plus word-addressed local data memory.
// Ports: clk; clrn (sync, active-low reset);
//   EXwreg/EXm2reg/EXwmem/EXwn/EXaluResult/EXdi from execute;
//   MEMwreg/MEMm2reg/MEMwn/MEMaluResult to MEM/WB;
//   MEMmo load data; MEMmisalign access-alignment flag.
// Macro PIPE_MEM_MISALIGN_EN enables misalignment detection:
//   flagged stores are dropped and flagged loads return 0.
module pipe_mem #(
  parameter int ADDR_W = 5
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        EXwreg,
  input  logic        EXm2reg,
  input  logic        EXwmem,
  input  logic [4:0]  EXwn,
  input  logic [31:0] EXaluResult,
  input  logic [31:0] EXdi,
  output logic        MEMwreg,
  output logic        MEMm2reg,
  output logic [4:0]  MEMwn,
  output logic [31:0] MEMaluResult,
  output logic [31:0] MEMmo,
  output logic        MEMmisalign
);
  logic              wreg_q, m2reg_q, wmem_q;
  logic [4:0]        wn_q;
  logic [31:0]       alu_q, di_q;
  logic [31:0]       mem_q [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] idx;
  logic              mis;
  logic              we_d;
  always_ff @(posedge clk) begin
    if (!clrn) begin
      wreg_q  <= 1'b0;
      m2reg_q <= 1'b0;
      wmem_q  <= 1'b0;
      wn_q    <= '0;
      alu_q   <= '0;
      di_q    <= '0;
    end else begin
      wreg_q  <= EXwreg;
      m2reg_q <= EXm2reg;
      wmem_q  <= EXwmem;
      wn_q    <= EXwn;
      alu_q   <= EXaluResult;
      di_q    <= EXdi;
    end
  end
  assign idx = alu_q[ADDR_W+1:2];
`ifdef PIPE_MEM_MISALIGN_EN
  assign mis   = (wmem_q | m2reg_q) & (alu_q[1:0] != 2'b00);
  assign MEMmo = mis ? 32'h0 : mem_q[idx];
`else
  assign mis   = 1'b0;
  assign MEMmo = mem_q[idx];
`endif
  // reset at the ending edge discards the store held in the register
  assign we_d = clrn & wmem_q & ~mis;
  always_ff @(posedge clk) begin
    if (we_d) mem_q[idx] <= di_q;
  end
  assign MEMwreg      = wreg_q;
  assign MEMm2reg     = m2reg_q;
  assign MEMwn        = wn_q;
  assign MEMaluResult = alu_q;
  assign MEMmisalign  = mis;
endmodule

// File: tb/tb_pipe_mem.sv
// tb_pipe_mem: scoreboard bench for pipe_mem with directed vectors.
module tb_pipe_mem;
`ifdef PIPE_MEM_MISALIGN_EN
  localparam bit MIS = 1'b1;
`else
  localparam bit MIS = 1'b0;
`endif
  typedef struct {
    logic        wreg, m2reg, mis, chk_mo;
    logic [4:0]  wn;
    logic [31:0] alu, mo;
  } exp_t;
  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        EXwreg = 1'b0, EXm2reg = 1'b0, EXwmem = 1'b0;
  logic [4:0]  EXwn = '0;
  logic [31:0] EXaluResult = '0, EXdi = '0;
  logic        MEMwreg, MEMm2reg, MEMmisalign;
  logic [4:0]  MEMwn;
  logic [31:0] MEMaluResult, MEMmo;
  int checks = 0;
  int errors = 0;
  exp_t sb[$];
  pipe_mem dut (
    .clk(clk), .clrn(clrn), .EXwreg(EXwreg), .EXm2reg(EXm2reg), .EXwmem(EXwmem),
    .EXwn(EXwn), .EXaluResult(EXaluResult), .EXdi(EXdi), .MEMwreg(MEMwreg),
    .MEMm2reg(MEMm2reg), .MEMwn(MEMwn), .MEMaluResult(MEMaluResult), .MEMmo(MEMmo),
    .MEMmisalign(MEMmisalign)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
    end
  endtask
  task automatic issue(input logic rn, w, m2, wm, input logic [4:0] n,
                       input logic [31:0] a, d, input logic cm,
                       input logic [31:0] mo, input logic mis);
    exp_t e;
    @(negedge clk);
    clrn = rn; EXwreg = w; EXm2reg = m2; EXwmem = wm; EXwn = n; EXaluResult = a; EXdi = d;
    @(posedge clk);
    e.wreg = rn & w; e.m2reg = rn & m2; e.wn = rn ? n : 5'd0; e.alu = rn ? a : 32'd0;
    e.chk_mo = cm; e.mo = mo; e.mis = mis;
    sb.push_back(e);
  endtask
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("wreg", {31'd0, MEMwreg}, {31'd0, e.wreg});
        chk("m2reg", {31'd0, MEMm2reg}, {31'd0, e.m2reg});
        chk("wn", {27'd0, MEMwn}, {27'd0, e.wn});
        chk("aluResult", MEMaluResult, e.alu);
        chk("misalign", {31'd0, MEMmisalign}, {31'd0, e.mis});
        if (e.chk_mo) chk("mo", MEMmo, e.mo);
      end
    end
  end
  initial begin
    int budget;
    // reset with nonzero inputs
    issue(0, 1, 1, 1, 5'd9, 32'h0000_0010, 32'hFFFF_FFFF, 0, 0, 0);
    issue(0, 1, 1, 1, 5'd9, 32'h0000_0010, 32'hFFFF_FFFF, 0, 0, 0);
    // store then load
    issue(1, 0, 0, 1, 5'd3, 32'h0000_0010, 32'hDEAD_BEEF, 0, 0, 0);
    issue(1, 1, 1, 0, 5'd5, 32'h0000_0010, 32'h0, 1, 32'hDEAD_BEEF, 0);
    // address wrap: 0x84 aliases 0x04
    issue(1, 0, 0, 1, 5'd0, 32'h0000_0084, 32'h1234_5678, 0, 0, 0);
    issue(1, 1, 1, 0, 5'd6, 32'h0000_0004, 32'h0, 1, 32'h1234_5678, 0);
    // reset while a store sits in the register
    issue(1, 0, 0, 1, 5'd0, 32'h0000_0020, 32'h1111_1111, 0, 0, 0);
    issue(1, 0, 0, 1, 5'd0, 32'h0000_0020, 32'hAAAA_5555, 0, 0, 0);
    issue(0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 0, 0);
    issue(1, 1, 1, 0, 5'd8, 32'h0000_0020, 32'h0, 1, 32'h1111_1111, 0);
    // pass-through leaves memory untouched
    issue(1, 0, 0, 1, 5'd0, 32'h0000_0040, 32'h0BAD_F00D, 0, 0, 0);
    issue(1, 1, 0, 0, 5'd7, 32'h0000_0042, 32'hFFFF_FFFF, 1, 32'h0BAD_F00D, 0);
    issue(1, 1, 1, 0, 5'd10, 32'h0000_0040, 32'h0, 1, 32'h0BAD_F00D, 0);
    // combined store+load reads the old word
    issue(1, 0, 0, 1, 5'd0, 32'h0000_0030, 32'h0000_0003, 0, 0, 0);
    issue(1, 1, 1, 1, 5'd11, 32'h0000_0030, 32'h0000_0005, 1, 32'h0000_0003, 0);
    issue(1, 1, 1, 0, 5'd12, 32'h0000_0030, 32'h0, 1, 32'h0000_0005, 0);
    // misaligned store/load
    issue(1, 0, 0, 1, 5'd0, 32'h0000_0008, 32'h0000_0000, 0, 0, 0);
    issue(1, 0, 0, 1, 5'd0, 32'h0000_000A, 32'hFFFF_FFFF, 0, 0, MIS);
    issue(1, 1, 1, 0, 5'd13, 32'h0000_000A, 32'h0, 1, MIS ? 32'h0 : 32'hFFFF_FFFF, MIS);
    issue(1, 1, 1, 0, 5'd14, 32'h0000_0008, 32'h0, 1, MIS ? 32'h0 : 32'hFFFF_FFFF, 0);
    // earlier data survived everything since
    issue(1, 1, 1, 0, 5'd15, 32'h0000_0010, 32'h0, 1, 32'hDEAD_BEEF, 0);
    budget = 20;
    while (sb.size() != 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #2;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d entries left, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", checks, errors);
    $finish;
  end
endmodule
